pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage ARM pipeline. It combines the MEM-stage memory handshake (SRAM/cache), the EXE-stage branch decision and the ID-stage load-use hazard into per-register freeze/flush controls for the PC and the IF/ID/EXE/MEM stage registers. It also enforces a memory-wait watchdog and keeps saturating performance counters. It sits beside the datapath, and every stage register takes its freeze/flush from here.

## Interface
- TIMEOUT, 255: maximum consecutive memory-wait cycles before the block declares an error (≥1).
- CNT_W, 32: width of each performance counter.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  in  1  MEM-stage instruction performs a load/store.
- mem_ready  in  1  memory system has completed the current access.
- branch_taken  in  1  EXE-stage branch resolved taken.
- hazard  in  1  load-use hazard detected in ID.
- perf_clr  in  1  synchronous clear of all counters.
- pc_freeze  out  1  hold the PC.
- pc_sel_branch  out  1  PC loads the branch target.
- if_freeze, if_flush  out  1 each  IF/ID register controls.
- id_freeze, id_flush  out  1 each  ID/EXE register controls.
- exe_freeze, mem_freeze  out  1 each  EXE/MEM and MEM/WB register holds.
- wb_bubble  out  1  suppress the WB write.
- timeout_err  out  1  sticky watchdog error.
- stall_cnt, hazard_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Define `mstall = mem_req & ~mem_ready`, or state==MEM_WAIT & ~mem_ready.
- Priority from highest to lowest: ERROR, mstall, branch, hazard.
- ERROR:
  - All freezes = 1, wb_bubble = 1, all flushes = 0, pc_sel_branch = 0, timeout_err = 1.
  - Only rst leaves ERROR.
- mstall:
  - pc_freeze, if_freeze, id_freeze, exe_freeze, mem_freeze and wb_bubble = 1.
  - All flushes = 0 and pc_sel_branch = 0. A flush must never be issued while the memory access is held.
- Branch (no mstall):
  - Condition: branch_taken | branch_pending.
  - if_flush = 1, id_flush = 1, pc_sel_branch = branch_taken.
  - Any simultaneous hazard is ignored, because the hazard instruction is squashed.
- Hazard (no mstall, no branch): pc_freeze = 1, if_freeze = 1, id_flush = 1 (bubble into EXE).
- Otherwise every output is 0.
- branch_pending register:
  - Set when branch_taken is high during an mstall cycle.
  - Cleared on the first non-mstall cycle, which is also the cycle in which the flush is applied.
- Transitions:
  - RUN → MEM_WAIT when mem_req & ~mem_ready.
  - MEM_WAIT → RUN on mem_ready.
  - MEM_WAIT → ERROR when wait_cnt == TIMEOUT-1 and ~mem_ready.
- wait_cnt: cleared in RUN, incremented each MEM_WAIT cycle. Width is clog2(TIMEOUT+1).
- Counters:
  - stall_cnt increments per mstall cycle.
  - hazard_cnt increments per cycle in which the hazard action is applied.
  - flush_cnt increments per cycle in which if_flush is asserted.
  - All counters saturate at 2^CNT_W−1.
  - perf_clr zeroes all counters and takes priority over increments in the same cycle.

## Timing
- All control outputs are combinational from state, branch_pending and the inputs, so stage registers act on the very next clk edge. Added latency: 0 cycles.
- The FSM, branch_pending, wait_cnt and the counters are registered and update on posedge clk.
- Reset (async, any time including mid-wait): state = RUN, branch_pending = 0, wait_cnt = 0, timeout_err = 0, all counters 0. All combinational outputs then follow the RUN rules.
- A one-cycle access (mem_req & mem_ready in the same cycle) causes no stall and no state change.
- If mem_ready arrives in the same cycle the watchdog would expire, the transition goes to RUN; ready wins.
- hazard held for N cycles gives N freeze cycles. The block has no hazard memory.

## Structure
- Shared package `pipe_ctrl_pkg`: FSM state enum (RUN, MEM_WAIT, ERROR) and a freeze/flush bundle typedef reused by the stage registers.
- One sub-module, `sat_counter` (CNT_W parameter, inc, clr), instantiated three times.

## Test plan
- mem_req = 1, mem_ready low for 3 cycles then high → all freezes and wb_bubble high for exactly 3 cycles; stall_cnt = 3; state returns to RUN.
- branch_taken = 1 and hazard = 1 in the same cycle, no mstall → if_flush = id_flush = pc_sel_branch = 1, pc_freeze = 0; flush_cnt = 1, hazard_cnt = 0.
- branch_taken pulses during cycle 2 of a 4-cycle memory wait → no flush during the wait; if_flush = id_flush = 1 on the release cycle with pc_sel_branch = 0; branch_pending cleared.
- TIMEOUT = 4, mem_ready never asserted → ERROR entered after 4 MEM_WAIT cycles; timeout_err sticky; async rst clears it.
- CNT_W = 3, hazard held for 10 cycles → hazard_cnt saturates at 7. perf_clr asserted together with hazard → hazard_cnt = 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state type and stage freeze/flush bundle for the pipeline controller
// Exports state_e (RUN, MEM_WAIT, ERROR) and ctrl_t, the per-register control bundle.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;
  typedef struct packed {
    logic pc_freeze;
    logic pc_sel_branch;
    logic if_freeze;
    logic if_flush;
    logic id_freeze;
    logic id_flush;
    logic exe_freeze;
    logic mem_freeze;
    logic wb_bubble;
  } ctrl_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that overrides increment
// Ports: clk, rst (async, active-high), inc (count enable), clr (sync clear), cnt (value).
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign cnt = cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer combining memory wait, branch and load-use hazard
// Inputs: mem_req/mem_ready (MEM handshake), branch_taken (EXE), hazard (ID), perf_clr.
// Outputs: PC and stage-register freeze/flush controls, wb_bubble, sticky timeout_err,
// and saturating stall/hazard/flush performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  input  logic             hazard,
  input  logic             perf_clr,
  output logic             pc_freeze,
  output logic             pc_sel_branch,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_freeze,
  output logic             id_flush,
  output logic             exe_freeze,
  output logic             mem_freeze,
  output logic             wb_bubble,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic bp_q, bp_d;
  logic err, mstall, brn, act;
  ctrl_t c;
  assign err    = state_q == ERROR;
  assign mstall = ~mem_ready & (mem_req | state_q == MEM_WAIT);
  assign brn    = branch_taken | bp_q;
  // act: neither the error lockout nor a memory hold owns the pipeline this cycle
  assign act    = ~err & ~mstall;
  always_comb begin
    c = '0;
    c.pc_freeze     = ~act | (~brn & hazard);
    c.if_freeze     = ~act | (~brn & hazard);
    c.pc_sel_branch = act & branch_taken;
    c.if_flush      = act & brn;
    c.id_flush      = act & (brn | hazard);
    c.id_freeze     = ~act;
    c.exe_freeze    = ~act;
    c.mem_freeze    = ~act;
    c.wb_bubble     = ~act;
  end
  assign {pc_freeze, pc_sel_branch, if_freeze, if_flush, id_freeze, id_flush,
          exe_freeze, mem_freeze, wb_bubble} = c;
  assign timeout_err = err;
  // mem_ready is tested before the watchdog so a late completion still returns to RUN
  assign state_d = err ? ERROR :
                   state_q == RUN ? (mstall ? MEM_WAIT : RUN) :
                   mem_ready ? RUN :
                   wait_q == WW'(TIMEOUT - 1) ? ERROR : MEM_WAIT;
  assign wait_d = state_q == MEM_WAIT ? wait_q + 1'b1 : '0;
  // a branch resolved under a memory hold is remembered and flushed on release
  assign bp_d = mstall & (bp_q | branch_taken);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      bp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bp_q    <= bp_d;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .inc(~err & mstall), .clr(perf_clr), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_hazard (
    .clk(clk), .rst(rst), .inc(act & ~brn & hazard), .clr(perf_clr), .cnt(hazard_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk(clk), .rst(rst), .inc(c.if_flush), .clr(perf_clr), .cnt(flush_cnt)
  );
endmodule
